// File: rtl/systolic_array.sv
// Output-stationary SIZE x SIZE systolic array of unsigned 8-bit MAC processing elements.
// Computes C = A*B over a fixed window of 3*SIZE-2 cycles, then raises done and holds C.
module systolic_array #(
    parameter int SIZE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_west  [SIZE],
    input  logic [7:0]  in_north [SIZE],
    output logic        done,
    output logic [31:0] result   [SIZE][SIZE]
);

    localparam logic [31:0] LAST = 32'(3 * SIZE - 2);

    logic [31:0] cnt;
    logic        active;

    logic [7:0]  a_q  [SIZE][SIZE];
    logic [7:0]  b_q  [SIZE][SIZE];
    logic [31:0] acc  [SIZE][SIZE];

    logic [7:0]  a_in [SIZE][SIZE];
    logic [7:0]  b_in [SIZE][SIZE];
    logic [15:0] prod [SIZE][SIZE];

    // Once the window closes every register freezes, so result stays stable while done=1.
    assign active = (cnt < LAST);

    // Operand routing: edge PEs take the array inputs, inner PEs take the neighbour's registered copy.
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            a_in[i][0] = in_west[i];
            b_in[0][i] = in_north[i];
        end
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 1; j < SIZE; j++) begin
                a_in[i][j] = a_q[i][j-1];
                b_in[j][i] = b_q[j-1][i];
            end
        end
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                prod[i][j] = a_in[i][j] * b_in[i][j];
            end
        end
    end

    // NOTE: every register here uses <= so all PEs sample their neighbours' pre-edge values,
    // which is what gives the one-cycle-per-hop skew through the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    a_q[i][j] <= '0;
                    b_q[i][j] <= '0;
                    acc[i][j] <= '0;
                end
            end
        end else if (active) begin
            cnt <= cnt + 32'd1;
            if (cnt == LAST - 32'd1) begin
                done <= 1'b1;
            end
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    a_q[i][j] <= a_in[i][j];
                    b_q[i][j] <= b_in[i][j];
                    acc[i][j] <= acc[i][j] + {16'd0, prod[i][j]};
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                result[i][j] = acc[i][j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: skewed matrix feeds checked against a plain
// matrix-product model, plus constant-input, hold-after-done and mid-run reset scenarios.
module tb_systolic_array;

    localparam int SIZE = 4;
    localparam int LAST = 3 * SIZE - 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_west  [SIZE];
    logic [7:0]  in_north [SIZE];
    logic        done;
    logic [31:0] result   [SIZE][SIZE];

    logic [7:0]  mat_a [SIZE][SIZE];
    logic [7:0]  mat_b [SIZE][SIZE];
    logic [31:0] exp_c [SIZE][SIZE];

    int checks = 0;
    int passes = 0;

    systolic_array #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_west  (in_west),
        .in_north (in_north),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_result(input string tag);
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                check($sformatf("%s c[%0d][%0d]", tag, i, j), result[i][j], exp_c[i][j]);
            end
        end
    endtask

    // Reference model: textbook matrix product, modulo 2^32.
    task automatic model_matmul();
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                logic [31:0] s;
                s = 32'd0;
                for (int k = 0; k < SIZE; k++) begin
                    s += 32'(mat_a[i][k]) * 32'(mat_b[k][j]);
                end
                exp_c[i][j] = s;
            end
        end
    endtask

    task automatic zero_inputs();
        for (int i = 0; i < SIZE; i++) begin
            in_west[i]  = 8'd0;
            in_north[i] = 8'd0;
        end
    endtask

    task automatic clear_expected();
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                exp_c[i][j] = 32'd0;
            end
        end
    endtask

    // One reset edge; leaves the bench at a negedge with rst released.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        in_west[0]  = 8'hA5;
        in_north[0] = 8'h5A;
        @(negedge clk);
        rst = 1'b0;
        zero_inputs();
        check({tag, " done after reset"}, 32'(done), 32'd0);
        clear_expected();
        check_result({tag, " reset"});
    endtask

    // Drives the skewed feed for cycles 0..n-1 and checks done after every edge.
    task automatic feed(input string tag, input int n);
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < SIZE; i++) begin
                in_west[i]  = (t - i >= 0 && t - i < SIZE) ? mat_a[i][t-i] : 8'd0;
                in_north[i] = (t - i >= 0 && t - i < SIZE) ? mat_b[t-i][i] : 8'd0;
            end
            @(negedge clk);
            check($sformatf("%s done t=%0d", tag, t), 32'(done), (t == LAST - 1) ? 32'd1 : 32'd0);
        end
        zero_inputs();
    endtask

    task automatic run_matmul(input string tag);
        do_reset(tag);
        model_matmul();
        feed(tag, LAST);
        check_result(tag);
    endtask

    task automatic set_identity();
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                mat_a[i][j] = (i == j) ? 8'd1 : 8'd0;
                mat_b[i][j] = (i == j) ? 8'd1 : 8'd0;
            end
        end
    endtask

    initial begin
        zero_inputs();

        // Constant inputs held for the whole window: only PE(0,0) ever sees a nonzero product.
        do_reset("const");
        in_west[0]  = 8'd1;
        in_north[0] = 8'd1;
        for (int t = 0; t < LAST + 3; t++) begin
            @(negedge clk);
            check($sformatf("const done t=%0d", t), 32'(done), (t >= LAST - 1) ? 32'd1 : 32'd0);
        end
        zero_inputs();
        clear_expected();
        exp_c[0][0] = 32'(LAST);
        check_result("const");

        set_identity();
        run_matmul("ident");

        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                mat_a[i][j] = 8'd255;
                mat_b[i][j] = 8'd255;
            end
        end
        run_matmul("dense255");
        check("dense255 literal", result[SIZE-1][SIZE-1], 32'd260100);

        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                mat_a[i][j] = 8'(i * SIZE + j + 1);
                mat_b[i][j] = (i == j) ? 8'd1 : 8'd0;
            end
        end
        run_matmul("seqxI");
        check("seqxI literal", result[2][1], 32'd10);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    mat_a[i][j] = 8'($urandom_range(0, 255));
                    mat_b[i][j] = 8'($urandom_range(0, 255));
                end
            end
            run_matmul($sformatf("rand%0d", r));
        end

        // Hold after done: random nonzero inputs must not disturb the frozen result.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < SIZE; i++) begin
                in_west[i]  = 8'($urandom_range(1, 255));
                in_north[i] = 8'($urandom_range(1, 255));
            end
            @(negedge clk);
            check($sformatf("hold done t=%0d", t), 32'(done), 32'd1);
        end
        zero_inputs();
        check_result("hold");

        // Mid-run reset: abort a random run after 5 active cycles, then a clean identity run.
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                mat_a[i][j] = 8'($urandom_range(1, 255));
                mat_b[i][j] = 8'($urandom_range(1, 255));
            end
        end
        do_reset("abort");
        feed("abort", 5);
        set_identity();
        run_matmul("rerun");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/systolic_array.md
Name: systolic_array

Overview:
- Output-stationary SIZE x SIZE systolic matrix-multiply array of unsigned 8-bit multiply-accumulate PEs.
- Operand A rows enter from the west edge and operand B columns from the north edge.
- Each PE accumulates its C element locally.
- After a fixed compute window the block raises done and holds the full result matrix for the surrounding NPU datapath to read.

Parameters:
- SIZE, 4, array dimension (rows = columns = SIZE); C = A·B with A, B, C all SIZE x SIZE.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_west  input  [SIZE] x 8  unpacked array; element i is the A value fed into row i this cycle (unsigned).
- in_north  input  [SIZE] x 8  unpacked array; element j is the B value fed into column j this cycle (unsigned).
- done  output  1  high once the compute window has finished; sticky until reset.
- result  output  [SIZE][SIZE] x 32  unpacked 2-D array; result[i][j] = accumulator of PE(i,j).

Behaviour:
- Reset (rst=1 at a rising edge) clears, at that edge:
  - all PE accumulators (result = 0);
  - all east/south pipeline registers;
  - the cycle counter;
  - done = 0.
- Reset mid-operation or after done aborts the computation and restarts the window cleanly; inputs are ignored while rst=1.
- PE(i,j) datapath:
  - Operand a_in is in_west[i] for j=0, otherwise the registered a_out of PE(i,j-1).
  - Operand b_in is in_north[j] for i=0, otherwise the registered b_out of PE(i-1,j).
  - On each active edge: acc <= acc + a_in*b_in; a_out <= a_in; b_out <= b_in.
  - Net effect: one cycle of delay per hop east or south.
- Arithmetic:
  - 8x8 unsigned product is 16 bits, zero-extended to 32 bits.
  - Accumulation is modulo 2^32; no saturation, no overflow flag.
- Control:
  - 32-bit-safe counter cnt, reset to 0.
  - An edge is active when rst=0 and cnt < 3*SIZE-2; at each active edge cnt increments.
  - Exactly 3*SIZE-2 active edges follow reset (10 for SIZE=4).
- done:
  - Registered; asserts at the same edge where cnt reaches 3*SIZE-2, i.e. visible after the (3*SIZE-2)th post-reset edge.
  - Stays high until the next reset.
  - When cnt = 3*SIZE-2, accumulators and pipeline registers hold their values regardless of inputs, so result is stable while done=1.
- Feeding convention (caller's responsibility; the block adds no internal skew):
  - At active cycle t (0-based after reset), drive in_west[i] = A[i][t-i] and in_north[j] = B[t-j][j] when the index is in 0..SIZE-1, else 0.
  - PE(i,j) then sees A[i][k] and B[k][j] together at cycle t = i+j+k, so the window of 3*SIZE-2 cycles covers every term.
- Constant inputs: held inputs are simply re-accumulated each active cycle.
  - Example: in_west[0]=in_north[0]=1, all others 0, held constant.
  - Result: result[0][0]=3*SIZE-2 (10 for SIZE=4), all other entries 0.
- result is driven directly from the accumulator registers, with no extra output latency.

Test Plan:
- Reset check: rst=1 for 1 edge -> done=0, all result entries 0; counter restarts on release.
- Constant inputs: in_west={1,0,0,0}, in_north={1,0,0,0} held after reset -> done rises after the 10th edge; result[0][0]=10, all other entries 0.
- Identity: skewed feed A=B=I4 -> done after 10 edges; result = I4 (diagonal 1, rest 0).
- Dense values: skewed feed A all 255, B all 255 -> every result[i][j]=4*65025=260100; also A=[[1,2,3,4],...row r = r*4+1..r*4+4], B=I4 -> result=A.
- Hold after done: after done, drive random nonzero inputs for 20 cycles -> result and done unchanged.
- Mid-run reset: assert rst at active cycle 5, then rerun the identity feed -> result = I4 with no residue from the aborted run; done timing identical to a fresh start.
